// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared types, widths and region-table accessors for the ROM
// download loader.
//   dl_state_e           : loader FSM states
//   reg_base() / reg_aw() : pull region i's base / address width out of the
//                           packed parameter vectors (region 0 in the LSBs)
package rom_dl_pkg;

  localparam int MAX_NREG = 8;   // largest supported region count
  localparam int DEF_INAW = 25;  // default stream address width
  localparam int ROM_AW   = 16;  // region-local address width
  localparam int BASE_W   = 24;  // per-region base field width
  localparam int AWW      = 5;   // per-region address-width field width
  localparam int HOLD_W   = 4;   // WE hold counter width (WE_HOLD <= 15)

  localparam int BVEC_W   = MAX_NREG * BASE_W;
  localparam int AVEC_W   = MAX_NREG * AWW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } dl_state_e;

  function automatic logic [BASE_W-1:0] reg_base(input logic [BVEC_W-1:0] v,
                                                 input int i);
    return v[i*BASE_W +: BASE_W];
  endfunction

  function automatic logic [AWW-1:0] reg_aw(input logic [AVEC_W-1:0] v,
                                           input int i);
    return v[i*AWW +: AWW];
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode: combinational region lookup for one stream address.
//   i_addr : stream byte address
//   o_hit  : one-hot region hit; the lowest matching region wins overlaps
//   o_lad  : address relative to the winning region's base (low 16 bits)
// Both outputs are zero when no region matches.
module rom_region_decode
  import rom_dl_pkg::*;
#(
  parameter int                      NREG     = 8,
  parameter int                      INAW     = DEF_INAW,
  parameter logic [NREG*BASE_W-1:0]  REG_BASE = '0,
  parameter logic [NREG*AWW-1:0]     REG_AW   = '0
) (
  input  logic [INAW-1:0]   i_addr,
  output logic [NREG-1:0]   o_hit,
  output logic [ROM_AW-1:0] o_lad
);

  // Two spare bits so base + 2**AW can never wrap in the compare.
  localparam int CW = ((INAW > BASE_W) ? INAW : BASE_W) + 2;
  localparam logic [BVEC_W-1:0] BV = BVEC_W'(REG_BASE);
  localparam logic [AVEC_W-1:0] AV = AVEC_W'(REG_AW);

  logic [CW-1:0]                w_a;
  logic [NREG-1:0]              w_raw;
  logic [NREG-1:0][ROM_AW-1:0]  w_loc;

  assign w_a = CW'(i_addr);

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    localparam logic [CW-1:0] LO = CW'(reg_base(BV, g));
    localparam logic [CW-1:0] HI = LO + (CW'(1) << reg_aw(AV, g)) - CW'(1);
    assign w_raw[g] = (w_a >= LO) && (w_a <= HI);
    assign w_loc[g] = ROM_AW'(w_a - LO);
  end

  // Walk from the top index down so the lowest matching region is the last
  // (and therefore surviving) assignment.
  always_comb begin
    o_hit = '0;
    o_lad = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (w_raw[i]) begin
        o_hit    = '0;
        o_hit[i] = 1'b1;
        o_lad    = w_loc[i];
      end
    end
  end

endmodule

// File: rtl/rom_download_loader.sv
// rom_download_loader: turns the HPS download byte stream into per-region
// ROM write pulses and holds the CPUs in reset until a download is flushed.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_dl_act/_wr/_addr/_data : host download stream
//   o_dl_wait                : stall request to host (only when WE_HOLD > 1)
//   o_rom_ad/_di/_we         : region-local address, data, one-hot write enable
//   o_cpu_rst                : high except after a completed download
//   o_dl_err                 : sticky; unmapped byte or strobe during stall
// Pipeline: stage 1 captures the byte, stage 2 decodes and drives the ROM
// port, so ROM_WE rises two clocks after the accepted strobe.
module rom_download_loader
  import rom_dl_pkg::*;
#(
  parameter int                      NREG     = 8,
  parameter int                      INAW     = DEF_INAW,
  parameter logic [NREG*BASE_W-1:0]  REG_BASE = {NREG{24'h0}},
  parameter logic [NREG*AWW-1:0]     REG_AW   = {NREG{5'd0}},
  parameter int                      WE_HOLD  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dl_act,
  input  logic              i_dl_wr,
  input  logic [INAW-1:0]   i_dl_addr,
  input  logic [7:0]        i_dl_data,
  output logic              o_dl_wait,
  output logic [ROM_AW-1:0] o_rom_ad,
  output logic [7:0]        o_rom_di,
  output logic [NREG-1:0]   o_rom_we,
  output logic              o_cpu_rst,
  output logic              o_dl_err
);

  dl_state_e           r_state, w_nxt;
  logic                w_err_clr;

  logic                r_s1_vld;
  logic [INAW-1:0]     r_s1_addr;
  logic [7:0]          r_s1_data;

  logic [NREG-1:0]     w_hit;
  logic [ROM_AW-1:0]   w_lad;

  logic [NREG-1:0]     r_rom_we;
  logic [ROM_AW-1:0]   r_rom_ad;
  logic [7:0]          r_rom_di;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_cpu_rst;
  logic                r_err;

  logic                w_busy, w_acc, w_drop;

  // Busy while a byte sits in stage 1 or a WE pulse is still running.
  // Single-cycle pulses never need to stall, so WE_HOLD=1 streams at 1 B/clk.
  assign w_busy    = r_s1_vld | (|r_rom_we);
  assign o_dl_wait = (WE_HOLD > 1) ? w_busy : 1'b0;
  assign w_acc     = (r_state == LOAD) && i_dl_wr && !o_dl_wait;
  assign w_drop    = (r_state == LOAD) && i_dl_wr &&  o_dl_wait;

  rom_region_decode #(
    .NREG     (NREG),
    .INAW     (INAW),
    .REG_BASE (REG_BASE),
    .REG_AW   (REG_AW)
  ) u_dec (
    .i_addr (r_s1_addr),
    .o_hit  (w_hit),
    .o_lad  (w_lad)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cpu_rst <= 1'b1;
    end else begin
      r_state   <= w_nxt;
      r_cpu_rst <= (w_nxt != DONE);
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_err_clr = 1'b0;
    case (r_state)
      IDLE:  if (i_dl_act) w_nxt = LOAD;
      LOAD:  if (!i_dl_act) w_nxt = FLUSH;
      FLUSH: if (!w_busy) w_nxt = DONE;
      DONE:  if (i_dl_act) w_nxt = LOAD;
      default: w_nxt = IDLE;
    endcase
    if (w_nxt == LOAD && r_state != LOAD) w_err_clr = 1'b1;
  end

  // ---------------- stage 1: capture ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_addr <= i_dl_addr;
        r_s1_data <= i_dl_data;
      end
    end
  end

  // ---------------- stage 2: decode + WE pulse ----------------
  // A new byte always reloads the pulse; with WE_HOLD>1 the stall keeps a new
  // byte from arriving before the previous pulse has ended.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rom_we <= '0;
      r_rom_ad <= '0;
      r_rom_di <= '0;
      r_hold   <= '0;
    end else if (r_s1_vld) begin
      r_rom_we <= w_hit;
      r_hold   <= HOLD_W'(WE_HOLD - 1);
      if (|w_hit) begin
        r_rom_ad <= w_lad;
        r_rom_di <= r_s1_data;
      end
    end else if (|r_rom_we) begin
      if (r_hold == '0) r_rom_we <= '0;
      else              r_hold   <= r_hold - HOLD_W'(1);
    end
  end

  // ---------------- sticky error ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                            r_err <= 1'b0;
    else if (w_err_clr)                      r_err <= 1'b0;
    else if (w_drop || (r_s1_vld && !(|w_hit))) r_err <= 1'b1;
  end

  assign o_rom_we  = r_rom_we;
  assign o_rom_ad  = r_rom_ad;
  assign o_rom_di  = r_rom_di;
  assign o_cpu_rst = r_cpu_rst;
  assign o_dl_err  = r_err;

endmodule

// File: tb/tb_rom_download_loader.sv
// Scoreboard bench: the stimulus side decodes each byte with a plain
// base/size table and queues the expected ROM write; a monitor pops and
// compares whenever ROM_WE is seen. A second instance with WE_HOLD=4
// covers the stall handshake with directed cycle checks.
module tb_rom_download_loader;

  localparam logic [8*24-1:0] P_BASE = {24'h050000, 24'h030000, 24'h008000,
                                        24'h020000, 24'h010000, 24'h008000,
                                        24'h004000, 24'h000000};
  localparam logic [8*5-1:0]  P_AW   = {5'd0, 5'd16, 5'd10, 5'd4,
                                        5'd8, 5'd12, 5'd13, 5'd14};

  int m_base [8] = '{32'h0, 32'h4000, 32'h8000, 32'h10000,
                     32'h20000, 32'h8000, 32'h30000, 32'h50000};
  int m_aw   [8] = '{14, 13, 12, 8, 4, 10, 16, 0};

  logic        clk, rst_n;
  logic        dl_act, dl_wr, dl_wait, cpu_rst, dl_err;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data, rom_di;
  logic [15:0] rom_ad;
  logic [7:0]  rom_we;

  logic        act4, wr4, wait4, cpu4, err4;
  logic [24:0] addr4;
  logic [7:0]  data4, di4, we4;
  logic [15:0] ad4;

  rom_download_loader #(.NREG(8), .INAW(25), .REG_BASE(P_BASE),
                        .REG_AW(P_AW), .WE_HOLD(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dl_act(dl_act), .i_dl_wr(dl_wr),
    .i_dl_addr(dl_addr), .i_dl_data(dl_data), .o_dl_wait(dl_wait),
    .o_rom_ad(rom_ad), .o_rom_di(rom_di), .o_rom_we(rom_we),
    .o_cpu_rst(cpu_rst), .o_dl_err(dl_err));

  rom_download_loader #(.NREG(8), .INAW(25), .REG_BASE(P_BASE),
                        .REG_AW(P_AW), .WE_HOLD(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dl_act(act4), .i_dl_wr(wr4),
    .i_dl_addr(addr4), .i_dl_data(data4), .o_dl_wait(wait4),
    .o_rom_ad(ad4), .o_rom_di(di4), .o_rom_we(we4),
    .o_cpu_rst(cpu4), .o_dl_err(err4));

  typedef struct {
    logic [7:0]  we;
    logic [15:0] ad;
    logic [7:0]  di;
    int          c;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   exp_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Reference decode: first region whose [base, base+size) contains a.
  function automatic int ref_region(input int a);
    for (int i = 0; i < 8; i++)
      if (a >= m_base[i] && a < m_base[i] + (1 << m_aw[i])) return i;
    return -1;
  endfunction

  task automatic send(input int a, input logic [7:0] d, input bit last);
    int r;
    @(negedge clk);
    dl_wr = 1'b1; dl_addr = 25'(a); dl_data = d;
    if (last) dl_act = 1'b0;
    r = ref_region(a);
    if (r < 0) exp_err = 1'b1;
    else q.push_back('{we: 8'(1 << r), ad: 16'(a - m_base[r]), di: d, c: cyc});
  endtask

  task automatic finish_phase(input string tag);
    @(negedge clk);
    dl_wr = 1'b0; dl_act = 1'b0;
    for (int i = 0; i < 40 && cpu_rst; i++) @(negedge clk);
    chk({tag, "_cpu_rst"}, cpu_rst, 0);
    chk({tag, "_queue_empty"}, q.size(), 0);
    chk({tag, "_err"}, dl_err, exp_err);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_we"},      rom_we, 0);
    chk({tag, "_wait"},    dl_wait, 0);
    chk({tag, "_err"},     dl_err, 0);
    chk({tag, "_ad"},      rom_ad, 0);
    chk({tag, "_di"},      rom_di, 0);
  endtask

  // Monitor: every cycle with ROM_WE high is one write.
  always begin
    exp_t e;
    @(negedge clk);
    if (rst_n && |rom_we) begin
      if (q.size() == 0) chk("unexpected_we", rom_we, 0);
      else begin
        e = q.pop_front();
        chk("we", rom_we, e.we);
        chk("ad", rom_ad, e.ad);
        chk("di", rom_di, e.di);
        chk("latency", cyc - e.c, 2);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired actual=running required=finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r;
    rst_n = 0; dl_act = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
    act4 = 0; wr4 = 0; addr4 = '0; data4 = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_cpu4", cpu4, 1);
    rst_n = 1;

    // Full sequential stream over regions 0 and 1; DL_ACT drops with last byte.
    @(negedge clk); dl_act = 1'b1;
    for (int i = 0; i < 32'h6000; i++) send(i, 8'($urandom), i == 32'h5FFF);
    finish_phase("stream");

    // Boundaries, unmapped byte, overlap.
    @(negedge clk); dl_act = 1'b1;
    @(negedge clk); chk("reassert_cpu_rst", cpu_rst, 1);
    send(32'h3FFF, 8'h11, 0);
    send(32'h4000, 8'h22, 0);
    send(32'h6000, 8'h33, 0);
    send(32'h8000, 8'h44, 1);
    finish_phase("boundary");

    // Strobes in DONE are ignored; re-entry to LOAD clears the error.
    @(negedge clk); dl_wr = 1'b1; dl_addr = 25'h100; dl_data = 8'h99;
    @(negedge clk); dl_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_wr_err_kept", dl_err, 1);
    chk("done_wr_cpu_rst", cpu_rst, 0);
    dl_act = 1'b1;
    @(negedge clk);
    chk("reenter_cpu_rst", cpu_rst, 1);
    chk("reenter_err_clr", dl_err, 0);
    exp_err = 0;

    // Random traffic with gaps.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        r = int'($urandom_range(0, 7));
        a = m_base[r] + int'($urandom_range(0, 1 << m_aw[r]));
      end else a = int'($urandom_range(0, 32'h5FFFF));
      repeat ($urandom_range(0, 2)) begin @(negedge clk); dl_wr = 1'b0; end
      send(a, 8'($urandom), n == 399);
    end
    finish_phase("random");

    // Reset mid-download after byte 100, then restream from 0.
    @(negedge clk); dl_act = 1'b1;
    for (int i = 0; i < 100; i++) send(i, 8'($urandom), 0);
    @(negedge clk);
    #2 rst_n = 1'b0; dl_wr = 1'b0; q.delete();
    #1 chk_reset_vals("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1; exp_err = 0;
    for (int i = 0; i < 64; i++) send(i, 8'($urandom), i == 63);
    finish_phase("restream");

    // WE_HOLD=4 instance: pulse width, stall window, dropped strobe.
    @(negedge clk); act4 = 1'b1;
    @(negedge clk);
    chk("h4_wait_c0", wait4, 0);
    wr4 = 1'b1; addr4 = 25'h10; data4 = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("h4_we_c%0d", k), we4, (k >= 2 && k <= 5) ? 8'h01 : 8'h00);
      chk($sformatf("h4_wait_c%0d", k), wait4, (k >= 1 && k <= 5) ? 1 : 0);
      if (k >= 2 && k <= 5) begin
        chk($sformatf("h4_ad_c%0d", k), ad4, 16'h10);
        chk($sformatf("h4_di_c%0d", k), di4, 8'hA5);
      end
      wr4 = (k == 3);
      if (k == 3) begin addr4 = 25'h20; data4 = 8'h5A; end
    end
    chk("h4_drop_err", err4, 1);
    @(negedge clk); wr4 = 1'b1; addr4 = 25'h4000; data4 = 8'h3C;
    @(negedge clk); wr4 = 1'b0;
    @(negedge clk);
    chk("h4_second_we", we4, 8'h02);
    chk("h4_second_ad", ad4, 16'h0);
    chk("h4_second_di", di4, 8'h3C);
    act4 = 1'b0;
    for (int i = 0; i < 40 && cpu4; i++) @(negedge clk);
    chk("h4_cpu_rst_done", cpu4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
